// File: rtl/issue_ctrl_pkg.sv
// Shared types for the RV32 decode/execute boundary: decoded instruction layout,
// register scoreboard and issue FSM states, plus operand extraction helpers.
package issue_ctrl_pkg;

    typedef logic [4:0]  t_register;
    typedef logic [31:0] t_scoreboard;

    typedef enum logic [1:0] {
        OK_OP_IMM  = 2'd0,
        OK_LUI     = 2'd1,
        OK_AUIPC   = 2'd2,
        OK_UNKNOWN = 2'd3
    } t_op_kind;

    typedef enum logic [2:0] {
        FK_ADD  = 3'd0,
        FK_SLT  = 3'd1,
        FK_SLTU = 3'd2,
        FK_XOR  = 3'd3,
        FK_OR   = 3'd4,
        FK_AND  = 3'd5,
        FK_SLL  = 3'd6,
        FK_SRL  = 3'd7
    } t_funct;

    typedef struct packed {
        logic [11:0] imm;
        t_register   src;
        t_funct      funct;
        t_register   dest;
    } t_op_imm_instr;

    typedef struct packed {
        logic [19:0] imm;
        t_register   dest;
    } t_op_lui_instr;

    typedef struct packed {
        t_op_kind      kind;
        t_op_imm_instr op_imm_instr;
        t_op_lui_instr op_lui_instr;
    } t_decoded_instr;

    typedef enum logic [1:0] {
        IS_EMPTY  = 2'd0,
        IS_WAIT   = 2'd1,
        IS_ISSUED = 2'd2
    } t_issue_state;

    function automatic t_register instr_dest(input t_decoded_instr instr);
        t_register r;
        case (instr.kind)
            OK_OP_IMM: r = instr.op_imm_instr.dest;
            default:   r = instr.op_lui_instr.dest;
        endcase
        return r;
    endfunction

    // Only OP_IMM reads a register; x0 stands for "no source" elsewhere.
    function automatic t_register instr_src(input t_decoded_instr instr);
        t_register r;
        case (instr.kind)
            OK_OP_IMM: r = instr.op_imm_instr.src;
            default:   r = 5'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode, execute and writeback handshake bundle around the issue controller.
interface issue_ctrl_if;
    import issue_ctrl_pkg::*;

    logic           dec_valid;
    logic           dec_ready;
    t_decoded_instr dec_instr;
    logic           ex_valid;
    logic           ex_ready;
    t_decoded_instr ex_instr;
    logic           wb_valid;
    t_register      wb_reg;

    modport slave (
        input  dec_valid, dec_instr, ex_ready, wb_valid, wb_reg,
        output dec_ready, ex_valid, ex_instr
    );

    modport master (
        output dec_valid, dec_instr, ex_ready, wb_valid, wb_reg,
        input  dec_ready, ex_valid, ex_instr
    );

endinterface

// File: rtl/issue_ctrl_reg_scoreboard.sv
// Busy bit per architectural register with same-cycle writeback bypass on the
// hazard query; a set on the same register as a clear wins.
module reg_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        set_i,
    input  t_register   set_reg_i,
    input  logic        clr_i,
    input  t_register   clr_reg_i,
    input  t_register   src_i,
    input  t_register   dest_i,
    output logic        hazard_o,
    output t_scoreboard busy_o
);

    t_scoreboard busy_q;
    t_scoreboard busy_d;
    t_scoreboard busy_byp_s;
    logic        set_ok_s;

    assign set_ok_s = (set_reg_i != 5'd0) && (int'(set_reg_i) < NUM_REGS);
    assign busy_o   = busy_q;

    // Bypassed view, hazard query and next busy vector
    always_comb begin
        busy_byp_s = busy_q;
        if (clr_i) begin
            busy_byp_s[clr_reg_i] = 1'b0;
        end else begin
            busy_byp_s[clr_reg_i] = busy_q[clr_reg_i];
        end
        hazard_o = ((src_i != 5'd0) && busy_byp_s[src_i]) ||
                   ((dest_i != 5'd0) && busy_byp_s[dest_i]);
        if (clear_i) begin
            busy_d = '0;
        end else if (set_i && set_ok_s) begin
            busy_d            = busy_byp_s;
            busy_d[set_reg_i] = 1'b1;
        end else begin
            busy_d = busy_byp_s;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// Single-slot issue stage: holds one decoded instruction and releases it to
// execute once it is free of RAW/WAW hazards and under the in-flight limit.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush_i,
    issue_ctrl_if.slave                        bus,
    output logic                               illegal_o,
    output logic [STALL_CNT_W-1:0]             stall_cnt_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_o
);

    localparam int IFW = $clog2(MAX_INFLIGHT + 1);

    t_issue_state     state_q, state_d;
    t_decoded_instr   slot_q, slot_d;
    t_decoded_instr   ex_instr_q, ex_instr_d;
    logic             ex_valid_q, ex_valid_d;
    logic             illegal_q, illegal_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [IFW-1:0]   inflight_q, inflight_d;

    logic dec_ready_s;
    logic accept_s;
    logic hazard_s;
    logic limit_s;
    logic issue_s;
    logic wb_dec_s;

    assign dec_ready_s = !flush_i && ((state_q == IS_EMPTY) ||
                                      ((state_q == IS_ISSUED) && bus.ex_ready));
    assign accept_s    = bus.dec_valid && dec_ready_s;
    // A writeback in the same cycle frees a slot, so it lifts the limit.
    assign limit_s     = (inflight_q == IFW'(MAX_INFLIGHT)) && !bus.wb_valid;
    assign issue_s     = !flush_i && (state_q == IS_WAIT) &&
                         (slot_q.kind != OK_UNKNOWN) && !hazard_s && !limit_s;
    assign wb_dec_s    = bus.wb_valid && (inflight_q != '0);

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (flush_i),
        .set_i     (issue_s),
        .set_reg_i (instr_dest(slot_q)),
        .clr_i     (bus.wb_valid),
        .clr_reg_i (bus.wb_reg),
        .src_i     (instr_src(slot_q)),
        .dest_i    (instr_dest(slot_q)),
        .hazard_o  (hazard_s),
        .busy_o    ()
    );

    // Next-state and next-output logic for the issue FSM and its counters
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        ex_instr_d  = ex_instr_q;
        ex_valid_d  = ex_valid_q;
        illegal_d   = illegal_q;
        stall_cnt_d = stall_cnt_q;
        inflight_d  = inflight_q;
        if (flush_i) begin
            state_d    = IS_EMPTY;
            ex_valid_d = 1'b0;
            illegal_d  = 1'b0;
            inflight_d = '0;
        end else begin
            case (state_q)
                IS_EMPTY: begin
                    if (accept_s) begin
                        slot_d  = bus.dec_instr;
                        state_d = IS_WAIT;
                    end else begin
                        state_d = IS_EMPTY;
                    end
                end
                IS_WAIT: begin
                    if (slot_q.kind == OK_UNKNOWN) begin
                        illegal_d = 1'b1;
                        state_d   = IS_EMPTY;
                    end else if (issue_s) begin
                        ex_instr_d = slot_q;
                        ex_valid_d = 1'b1;
                        state_d    = IS_ISSUED;
                    end else if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
                        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
                    end else begin
                        stall_cnt_d = stall_cnt_q;
                    end
                end
                IS_ISSUED: begin
                    if (bus.ex_ready) begin
                        ex_valid_d = 1'b0;
                        if (accept_s) begin
                            slot_d  = bus.dec_instr;
                            state_d = IS_WAIT;
                        end else begin
                            state_d = IS_EMPTY;
                        end
                    end else begin
                        ex_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = IS_EMPTY;
                    ex_valid_d = 1'b0;
                end
            endcase
            if (issue_s && !wb_dec_s) begin
                inflight_d = inflight_q + IFW'(1);
            end else if (!issue_s && wb_dec_s) begin
                inflight_d = inflight_q - IFW'(1);
            end else begin
                inflight_d = inflight_q;
            end
        end
    end

    // FSM state, held instruction, outputs and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IS_EMPTY;
            slot_q      <= '0;
            ex_instr_q  <= '0;
            ex_valid_q  <= 1'b0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            ex_instr_q  <= ex_instr_d;
            ex_valid_q  <= ex_valid_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
            inflight_q  <= inflight_d;
        end
    end

    assign bus.dec_ready = dec_ready_s;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_instr  = ex_instr_q;
    assign illegal_o     = illegal_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign inflight_o    = inflight_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: latency, hazards with writeback bypass,
// illegal trap, in-flight limit, execute backpressure and async reset.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        illegal;
    logic [15:0] stall_cnt;
    logic [2:0]  inflight;
    int          checks = 0;
    int          failures = 0;

    issue_ctrl_if bus();

    issue_ctrl #(
        .NUM_REGS     (32),
        .MAX_INFLIGHT (4),
        .STALL_CNT_W  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .bus         (bus),
        .illegal_o   (illegal),
        .stall_cnt_o (stall_cnt),
        .inflight_o  (inflight)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic t_decoded_instr mk_opimm(input t_funct f, input t_register d,
                                                input t_register s, input logic [11:0] imm);
        t_decoded_instr i;
        i = '0;
        i.kind               = OK_OP_IMM;
        i.op_imm_instr.funct = f;
        i.op_imm_instr.dest  = d;
        i.op_imm_instr.src   = s;
        i.op_imm_instr.imm   = imm;
        return i;
    endfunction

    function automatic t_decoded_instr mk_lui(input t_register d);
        t_decoded_instr i;
        i = '0;
        i.kind              = OK_LUI;
        i.op_lui_instr.dest = d;
        i.op_lui_instr.imm  = 20'h12345;
        return i;
    endfunction

    task automatic do_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.dec_valid = 1'b0; bus.dec_instr = '0; bus.ex_ready = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_reg = 5'd0;
        #1;
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%0b exp=0", bus.ex_valid); end
        checks++; if (bus.ex_instr !== t_decoded_instr'(0)) begin failures++; $display("FAIL reset_ex_instr got=%h exp=0", bus.ex_instr); end
        checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%0b exp=0", illegal); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        checks++; if (dut.u_sb.busy_o !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", dut.u_sb.busy_o); end
        checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL reset_dec_ready got=%0b exp=1", bus.dec_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        t_decoded_instr i1;
        i1 = mk_opimm(FK_ADD, 5'd1, 5'd2, 12'd5);
        bus.dec_instr = i1; bus.dec_valid = 1'b1; bus.ex_ready = 1'b1;
        #1;
        checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL basic_dec_ready got=%0b exp=1", bus.dec_ready); end
        tick();
        bus.dec_valid = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL basic_ex_valid_c1 got=%0b exp=0", bus.ex_valid); end
        tick();
        checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL basic_ex_valid_c2 got=%0b exp=1", bus.ex_valid); end
        checks++; if (bus.ex_instr !== i1) begin failures++; $display("FAIL basic_ex_instr got=%h exp=%h", bus.ex_instr, i1); end
        checks++; if (inflight !== 3'd1) begin failures++; $display("FAIL basic_inflight got=%0d exp=1", inflight); end
        checks++; if (dut.u_sb.busy_o[1] !== 1'b1) begin failures++; $display("FAIL basic_busy1 got=%0b exp=1", dut.u_sb.busy_o[1]); end
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd1;
        tick();
        bus.wb_valid = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL basic_ex_valid_done got=%0b exp=0", bus.ex_valid); end
        checks++; if (dut.u_sb.busy_o[1] !== 1'b0) begin failures++; $display("FAIL basic_busy1_wb got=%0b exp=0", dut.u_sb.busy_o[1]); end
        checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL basic_inflight_wb got=%0d exp=0", inflight); end
    endtask

    task automatic test_raw_bypass;
        t_decoded_instr a, b;
        a = mk_opimm(FK_ADD, 5'd1, 5'd0, 12'd1);
        b = mk_opimm(FK_XOR, 5'd3, 5'd1, 12'd7);
        bus.ex_ready = 1'b1;
        bus.dec_instr = a; bus.dec_valid = 1'b1;
        tick();
        bus.dec_instr = b;
        tick();
        checks++; if (bus.ex_instr !== a) begin failures++; $display("FAIL raw_first_issue got=%h exp=%h", bus.ex_instr, a); end
        tick();
        bus.dec_valid = 1'b0;
        repeat (5) tick();
        checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL raw_stall_held got=%0d exp=5", stall_cnt); end
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL raw_held got=%0b exp=0", bus.ex_valid); end
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd1;
        tick();
        bus.wb_valid = 1'b0;
        checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL raw_bypass_issue got=%0b exp=1", bus.ex_valid); end
        checks++; if (bus.ex_instr !== b) begin failures++; $display("FAIL raw_second_instr got=%h exp=%h", bus.ex_instr, b); end
        checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL raw_stall_final got=%0d exp=5", stall_cnt); end
        checks++; if (inflight !== 3'd1) begin failures++; $display("FAIL raw_inflight got=%0d exp=1", inflight); end
        checks++; if (dut.u_sb.busy_o !== 32'h0000_0008) begin failures++; $display("FAIL raw_busy got=%h exp=00000008", dut.u_sb.busy_o); end
        tick();
        do_flush();
        checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL flush_inflight got=%0d exp=0", inflight); end
        checks++; if (dut.u_sb.busy_o !== 32'd0) begin failures++; $display("FAIL flush_busy got=%h exp=0", dut.u_sb.busy_o); end
        checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL flush_keeps_stall got=%0d exp=5", stall_cnt); end
    endtask

    task automatic test_illegal;
        t_decoded_instr u;
        u = '0;
        u.kind = OK_UNKNOWN;
        bus.dec_instr = u; bus.dec_valid = 1'b1;
        tick();
        bus.dec_valid = 1'b0;
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_early got=%0b exp=0", illegal); end
        tick();
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_set got=%0b exp=1", illegal); end
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL illegal_no_issue got=%0b exp=0", bus.ex_valid); end
        checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL illegal_dec_ready got=%0b exp=1", bus.dec_ready); end
        flush = 1'b1;
        #1;
        checks++; if (bus.dec_ready !== 1'b0) begin failures++; $display("FAIL flush_dec_ready got=%0b exp=0", bus.dec_ready); end
        tick();
        flush = 1'b0;
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_cleared got=%0b exp=0", illegal); end
    endtask

    task automatic test_limit;
        bus.ex_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            int n;
            bus.dec_instr = mk_lui(t_register'(i));
            bus.dec_valid = 1'b1;
            #1;
            n = 0;
            while (!bus.dec_ready && n < 8) begin
                tick();
                n++;
            end
            checks++; if (n >= 8) begin failures++; $display("FAIL limit_accept_timeout lui=%0d waited=%0d exp<8", i, n); end
            tick();
        end
        bus.dec_valid = 1'b0;
        checks++; if (inflight !== 3'd4) begin failures++; $display("FAIL limit_inflight got=%0d exp=4", inflight); end
        repeat (2) tick();
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL limit_held got=%0b exp=0", bus.ex_valid); end
        checks++; if (stall_cnt !== 16'd7) begin failures++; $display("FAIL limit_stall got=%0d exp=7", stall_cnt); end
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd2;
        tick();
        bus.wb_valid = 1'b0;
        checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL limit_issue got=%0b exp=1", bus.ex_valid); end
        checks++; if (bus.ex_instr !== mk_lui(5'd5)) begin failures++; $display("FAIL limit_instr got=%h exp=%h", bus.ex_instr, mk_lui(5'd5)); end
        checks++; if (inflight !== 3'd4) begin failures++; $display("FAIL limit_inflight_keep got=%0d exp=4", inflight); end
        checks++; if (dut.u_sb.busy_o !== 32'h0000_003A) begin failures++; $display("FAIL limit_busy got=%h exp=0000003a", dut.u_sb.busy_o); end
        tick();
        do_flush();
    endtask

    task automatic test_hold;
        t_decoded_instr h, n;
        h = mk_opimm(FK_AND, 5'd6, 5'd0, 12'd9);
        n = mk_lui(5'd7);
        bus.ex_ready = 1'b0;
        bus.dec_instr = h; bus.dec_valid = 1'b1;
        tick();
        bus.dec_instr = n;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%0b exp=1", k, bus.ex_valid); end
            checks++; if (bus.ex_instr !== h) begin failures++; $display("FAIL hold_instr cyc=%0d got=%h exp=%h", k, bus.ex_instr, h); end
            checks++; if (bus.dec_ready !== 1'b0) begin failures++; $display("FAIL hold_dec_ready cyc=%0d got=%0b exp=0", k, bus.dec_ready); end
            tick();
        end
        bus.ex_ready = 1'b1;
        #1;
        checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%0b exp=1", bus.dec_ready); end
        tick();
        bus.dec_valid = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL hold_drop_valid got=%0b exp=0", bus.ex_valid); end
        tick();
        checks++; if (bus.ex_instr !== n) begin failures++; $display("FAIL hold_next_instr got=%h exp=%h", bus.ex_instr, n); end
        tick();
        do_flush();
    endtask

    task automatic test_back_to_back;
        bus.ex_ready = 1'b1;
        bus.dec_instr = mk_lui(5'd0); bus.dec_valid = 1'b1;
        tick();
        tick();
        checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL x0_first_issue got=%0b exp=1", bus.ex_valid); end
        checks++; if (dut.u_sb.busy_o !== 32'd0) begin failures++; $display("FAIL x0_busy got=%h exp=0", dut.u_sb.busy_o); end
        tick();
        bus.dec_valid = 1'b0;
        tick();
        checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL x0_second_issue got=%0b exp=1", bus.ex_valid); end
        checks++; if (stall_cnt !== 16'd7) begin failures++; $display("FAIL x0_no_stall got=%0d exp=7", stall_cnt); end
        checks++; if (inflight !== 3'd2) begin failures++; $display("FAIL x0_inflight got=%0d exp=2", inflight); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL arst_ex_valid got=%0b exp=0", bus.ex_valid); end
        checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL arst_inflight got=%0d exp=0", inflight); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL arst_stall got=%0d exp=0", stall_cnt); end
        checks++; if (bus.ex_instr !== t_decoded_instr'(0)) begin failures++; $display("FAIL arst_ex_instr got=%h exp=0", bus.ex_instr); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_underflow;
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd3;
        tick();
        bus.wb_valid = 1'b0;
        checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL underflow_inflight got=%0d exp=0", inflight); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw_bypass();
        test_illegal();
        test_limit();
        test_hold();
        test_back_to_back();
        test_underflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
